calc1_port_driver: RTL and testbench

- Upstream request sequencer for one calc1 port (req*_cmd_in / req*_data_in, out_resp* / out_data*).
- Accepts a whole transaction (cmd, op1, op2) on a valid/ready interface and serialises it into calc1's two-cycle request protocol.
- Waits for the port response with a timeout and returns result/code on a valid/ready response interface.
- The top level instantiates four of these, one per calc1 port.

---
 rtl/calc1_pkg.sv | 32 +++
 rtl/calc1_wait_timer.sv | 41 ++++
 rtl/calc1_port_driver.sv | 165 ++++++++++++++++
 tb/tb_calc1_port_driver.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 request path: command/response codes,
// operand width and the port driver's sequencing states.
package calc1_pkg;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_RSV  = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_SEND_OP2,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/calc1_wait_timer.sv
// Saturating wait counter for the port driver; flags expiry once the count
// reaches TIMEOUT_CYCLES and holds there until cleared.
module calc1_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic c_clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_d = count_q + ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments and a synchronous
    // reset, so every flop samples the same pre-edge values.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/calc1_port_driver.sv
// Sequences one (cmd, op1, op2) transaction into a calc1 port's two-cycle
// request protocol and returns the port response, or a timeout completion.
module calc1_port_driver
    import calc1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              txn_valid,
    output logic              txn_ready,
    input  logic [CMD_W-1:0]  txn_cmd,
    input  logic [DATA_W-1:0] txn_op1,
    input  logic [DATA_W-1:0] txn_op2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_code,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_timeout,
    output logic [CMD_W-1:0]  calc_cmd,
    output logic [DATA_W-1:0] calc_data,
    input  logic [RESP_W-1:0] calc_resp,
    input  logic [DATA_W-1:0] calc_result,
    output logic              spurious_resp
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              txn_ready_q, txn_ready_d;
    logic [CMD_W-1:0]  calc_cmd_q, calc_cmd_d;
    logic [DATA_W-1:0] calc_data_q, calc_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RESP_W-1:0] rsp_code_q, rsp_code_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              spurious_q, spurious_d;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // Counting starts in SEND_OP2 so the first WAIT cycle already reads 1.
    assign timer_enable = (state_q == ST_SEND_OP2) || (state_q == ST_WAIT);

    calc1_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .c_clk     (c_clk),
        .reset     (reset),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        op2_d         = op2_q;
        calc_cmd_d    = '0;
        calc_data_d   = '0;
        rsp_code_d    = rsp_code_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        timer_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (txn_valid && txn_ready_q) begin
                    op2_d = txn_op2;
                    if (txn_cmd == CMD_NOP) begin
                        state_d       = ST_RESP;
                        rsp_code_d    = RESP_NONE;
                        rsp_data_d    = '0;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d     = ST_SEND_CMD;
                        calc_cmd_d  = txn_cmd;
                        calc_data_d = txn_op1;
                    end
                end
            end

            ST_SEND_CMD: begin
                state_d     = ST_SEND_OP2;
                calc_data_d = op2_q;
            end

            ST_SEND_OP2: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A response landing on the final wait cycle beats the timeout.
                if (calc_resp != RESP_NONE) begin
                    state_d       = ST_RESP;
                    rsp_code_d    = calc_resp;
                    rsp_data_d    = calc_result;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    state_d       = ST_RESP;
                    rsp_code_d    = RESP_NONE;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d       = ST_IDLE;
                    timer_clear   = 1'b1;
                    rsp_code_d    = '0;
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        txn_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        spurious_d  = spurious_q || ((state_q != ST_WAIT) && (calc_resp != RESP_NONE));
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op2_q         <= '0;
            txn_ready_q   <= 1'b0;
            calc_cmd_q    <= '0;
            calc_data_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_code_q    <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            op2_q         <= op2_d;
            txn_ready_q   <= txn_ready_d;
            calc_cmd_q    <= calc_cmd_d;
            calc_data_q   <= calc_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_code_q    <= rsp_code_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            spurious_q    <= spurious_d;
        end
    end

    assign txn_ready     = txn_ready_q;
    assign calc_cmd      = calc_cmd_q;
    assign calc_data     = calc_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_code      = rsp_code_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver: a transaction-level model checked every
// cycle, plus hand-computed expectations at the key points of each scenario.
module tb_calc1_port_driver;
    import calc1_pkg::*;

    localparam int T_OUT = 16;

    logic        c_clk = 1'b0;
    logic        reset;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_cmd;
    logic [31:0] txn_op1;
    logic [31:0] txn_op2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic [3:0]  calc_cmd;
    logic [31:0] calc_data;
    logic [1:0]  calc_resp;
    logic [31:0] calc_result;
    logic        spurious_resp;

    int n_checks = 0;
    int n_errors = 0;

    calc1_port_driver #(
        .TIMEOUT_CYCLES (T_OUT),
        .CNT_W          (8)
    ) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .txn_valid     (txn_valid),
        .txn_ready     (txn_ready),
        .txn_cmd       (txn_cmd),
        .txn_op1       (txn_op1),
        .txn_op2       (txn_op2),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_code      (rsp_code),
        .rsp_data      (rsp_data),
        .rsp_timeout   (rsp_timeout),
        .calc_cmd      (calc_cmd),
        .calc_data     (calc_data),
        .calc_resp     (calc_resp),
        .calc_result   (calc_result),
        .spurious_resp (spurious_resp)
    );

    always #5 c_clk = ~c_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an accepted transaction ages one step per
    // cycle; age 1 shows cmd/op1, age 2 shows op2, age >= 3 is waiting.
    bit          m_ready = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    bit          m_spur  = 0;
    int          m_age   = 0;
    logic [3:0]  m_cmd   = '0;
    logic [31:0] m_op1   = '0;
    logic [31:0] m_op2   = '0;
    logic [1:0]  m_code  = '0;
    logic [31:0] m_data  = '0;
    bit          m_to    = 0;
    logic [3:0]  e_cmd;
    logic [31:0] e_data;
    bit          was_reset;

    always @(posedge c_clk) begin
        was_reset = reset;
        if (reset) begin
            m_ready = 0; m_busy = 0; m_done = 0; m_spur = 0; m_age = 0;
            m_code = '0; m_data = '0; m_to = 0;
        end else begin
            if ((!m_busy || m_done || m_age <= 2) && calc_resp != 2'd0) m_spur = 1;
            if (!m_busy) begin
                if (m_ready && txn_valid) begin
                    m_busy = 1; m_ready = 0; m_age = 1;
                    m_cmd = txn_cmd; m_op1 = txn_op1; m_op2 = txn_op2;
                    if (txn_cmd == 4'd0) begin
                        m_done = 1; m_code = 2'd0; m_data = '0; m_to = 0;
                    end
                end else begin
                    m_ready = 1;
                end
            end else if (m_done) begin
                if (rsp_ready) begin
                    m_done = 0; m_busy = 0; m_ready = 1;
                end
            end else if (m_age <= 2) begin
                m_age++;
            end else if (calc_resp != 2'd0) begin
                m_done = 1; m_code = calc_resp; m_data = calc_result; m_to = 0;
            end else if (m_age - 2 == T_OUT) begin
                m_done = 1; m_code = 2'd0; m_data = '0; m_to = 1;
            end else begin
                m_age++;
            end
        end

        e_cmd  = (m_busy && !m_done && m_age == 1) ? m_cmd : 4'd0;
        e_data = (m_busy && !m_done && m_age == 1) ? m_op1 :
                 (m_busy && !m_done && m_age == 2) ? m_op2 : 32'd0;

        #1;
        check("cyc_txn_ready", 32'(txn_ready), 32'(m_ready));
        check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_done));
        check("cyc_calc_cmd", 32'(calc_cmd), 32'(e_cmd));
        check("cyc_calc_data", calc_data, e_data);
        check("cyc_spurious", 32'(spurious_resp), 32'(m_spur));
        if (m_done || was_reset) begin
            check("cyc_rsp_code", 32'(rsp_code), 32'(m_code));
            check("cyc_rsp_data", rsp_data, m_data);
            check("cyc_rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        end
    end

    // Called at a negedge with the driver idle; returns at the negedge of T+1.
    task automatic issue(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2);
        txn_valid = 1'b1;
        txn_cmd   = cmd;
        txn_op1   = op1;
        txn_op2   = op2;
        @(negedge c_clk);
        txn_valid = 1'b0;
    endtask

    // Called at the negedge of T+2; drives a response on WAIT cycle n (code 0
    // means silence) and returns at the negedge of the first RESP cycle.
    task automatic respond(input int n, input logic [1:0] code, input logic [31:0] data);
        repeat (n) @(negedge c_clk);
        calc_resp   = code;
        calc_result = data;
        @(negedge c_clk);
        calc_resp   = 2'd0;
        calc_result = '0;
    endtask

    task automatic check_rsp(input string name, input logic [1:0] code,
                             input logic [31:0] data, input logic to);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_code"}, 32'(rsp_code), 32'(code));
        check({name, "_data"}, rsp_data, data);
        check({name, "_timeout"}, 32'(rsp_timeout), 32'(to));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_txn_ready"}, 32'(txn_ready), 32'd0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_calc_cmd"}, 32'(calc_cmd), 32'd0);
        check({name, "_calc_data"}, calc_data, 32'd0);
        check({name, "_spurious"}, 32'(spurious_resp), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by %0t expected $finish", $time);
        $fatal(1, "bench did not terminate");
    end

    initial begin
        reset = 1'b1; txn_valid = 1'b0; txn_cmd = '0; txn_op1 = '0; txn_op2 = '0;
        rsp_ready = 1'b0; calc_resp = '0; calc_result = '0;

        repeat (3) @(negedge c_clk);
        check_all_zero("reset");
        check("reset_rsp_code", 32'(rsp_code), 32'd0);
        reset = 1'b0;
        @(negedge c_clk);
        check("ready_after_reset", 32'(txn_ready), 32'd1);
        rsp_ready = 1'b1;

        // Add 1 + 0x01FFFFFF, answered on WAIT cycle 3.
        issue(CMD_ADD, 32'h0000_0001, 32'h01FF_FFFF);
        check("add_t1_cmd", 32'(calc_cmd), 32'd1);
        check("add_t1_data", calc_data, 32'h0000_0001);
        check("add_t1_ready", 32'(txn_ready), 32'd0);
        @(negedge c_clk);
        check("add_t2_cmd", 32'(calc_cmd), 32'd0);
        check("add_t2_data", calc_data, 32'h01FF_FFFF);
        respond(3, RESP_OK, 32'h0200_0000);
        check_rsp("add_rsp", 2'd1, 32'h0200_0000, 1'b0);
        @(negedge c_clk);
        check("add_idle_ready", 32'(txn_ready), 32'd1);

        // Overflow, error response, then back-to-back issue.
        issue(CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge c_clk);
        respond(2, RESP_ERR, 32'h0000_0000);
        check_rsp("ovf_rsp", 2'd2, 32'h0, 1'b0);
        @(negedge c_clk);
        check("ovf_next_ready", 32'(txn_ready), 32'd1);
        issue(CMD_SUB, 32'd5, 32'd3);
        check("b2b_accept_cmd", 32'(calc_cmd), 32'd2);

        // Silent port: timeout completion after 16 WAIT cycles.
        @(negedge c_clk);
        respond(T_OUT, RESP_NONE, 32'h0);
        check_rsp("tmo_rsp", 2'd0, 32'h0, 1'b1);
        @(negedge c_clk);

        // Response on the final WAIT cycle wins over the timeout.
        issue(CMD_ADD, 32'd7, 32'd8);
        @(negedge c_clk);
        respond(T_OUT, RESP_OK, 32'h0000_000F);
        check_rsp("edge_rsp", 2'd1, 32'h0000_000F, 1'b0);
        @(negedge c_clk);

        // Backpressure: rsp_ready low 5 cycles with a second request pending.
        rsp_ready = 1'b0;
        issue(CMD_SHL, 32'h10, 32'd4);
        @(negedge c_clk);
        respond(1, RESP_OK, 32'h0000_0100);
        txn_valid = 1'b1; txn_cmd = CMD_SHR; txn_op1 = 32'h80; txn_op2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            check_rsp("bp_hold", 2'd1, 32'h0000_0100, 1'b0);
            check("bp_txn_ready", 32'(txn_ready), 32'd0);
            @(negedge c_clk);
        end
        rsp_ready = 1'b1;
        @(negedge c_clk);
        check("bp_idle_ready", 32'(txn_ready), 32'd1);
        @(negedge c_clk);
        txn_valid = 1'b0;
        check("bp_second_cmd", 32'(calc_cmd), 32'd6);
        check("bp_second_op1", calc_data, 32'h80);
        @(negedge c_clk);
        respond(1, RESP_OK, 32'h10);
        check_rsp("bp_second_rsp", 2'd1, 32'h10, 1'b0);
        @(negedge c_clk);

        // Reset in the middle of WAIT drops the transaction.
        issue(CMD_ADD, 32'd3, 32'd4);
        repeat (3) @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        check_all_zero("midreset");
        reset = 1'b0;
        @(negedge c_clk);
        check("midreset_ready", 32'(txn_ready), 32'd1);
        issue(CMD_ADD, 32'h10, 32'h20);
        check("fresh_cmd", 32'(calc_cmd), 32'd1);
        @(negedge c_clk);
        respond(1, RESP_OK, 32'h30);
        check_rsp("fresh_rsp", 2'd1, 32'h30, 1'b0);
        @(negedge c_clk);

        // NOP completes without touching the calc port.
        issue(CMD_NOP, 32'hDEAD, 32'hBEEF);
        check_rsp("nop_rsp", 2'd0, 32'h0, 1'b0);
        check("nop_calc_cmd", 32'(calc_cmd), 32'd0);
        check("nop_calc_data", calc_data, 32'd0);
        @(negedge c_clk);
        check("nop_idle_ready", 32'(txn_ready), 32'd1);

        // Spurious response while idle is sticky until reset.
        calc_resp = RESP_OK;
        @(negedge c_clk);
        calc_resp = RESP_NONE;
        check("spur_set", 32'(spurious_resp), 32'd1);
        check("spur_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge c_clk);
        check("spur_sticky", 32'(spurious_resp), 32'd1);
        issue(CMD_SUB, 32'd9, 32'd4);
        @(negedge c_clk);
        respond(2, RESP_OK, 32'd5);
        check_rsp("spur_txn_rsp", 2'd1, 32'd5, 1'b0);
        check("spur_still", 32'(spurious_resp), 32'd1);
        @(negedge c_clk);
        reset = 1'b1;
        @(negedge c_clk);
        check("spur_cleared", 32'(spurious_resp), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge c_clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
